// File: rtl/dmem_pkg.sv
// Shared types and constants for the pipelined data memory.
package dmem_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam int unsigned MAX_READ_LAT = 4;
    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_ADDR_W   = 8;

endpackage

// File: rtl/dmem_rdpipe.sv
// Load-response shift pipeline: LAT register stages of valid/data/err, flushed by rst.
module dmem_rdpipe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_err,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    logic [LAT-1:0]    v;
    logic [LAT-1:0]    e;
    logic [DATA_W-1:0] d [LAT];

    // Data/err stages only load behind a valid, so the output holds between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            e <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                d[i] <= '0;
            end
        end else begin
            v[0] <= in_valid;
            if (in_valid) begin
                d[0] <= in_data;
                e[0] <= in_err;
            end
            for (int unsigned i = 1; i < LAT; i++) begin
                v[i] <= v[i-1];
                if (v[i-1]) begin
                    d[i] <= d[i-1];
                    e[i] <= e[i-1];
                end
            end
        end
    end

    assign out_valid = v[LAT-1];
    assign out_data  = d[LAT-1];
    assign out_err   = e[LAT-1];

endmodule

// File: rtl/data_memory_pipe.sv
// Single-port data memory with valid/ready requests, byte-enabled stores,
// configurable read latency and an optional post-reset zero-fill.
module data_memory_pipe
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned INIT_ZERO = 1
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    if (DATA_W == 0 || DATA_W % 8 != 0) begin : g_bad_data_w
        $error("data_memory_pipe: DATA_W must be a non-zero multiple of 8");
    end
    if (longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
        $error("data_memory_pipe: DEPTH exceeds 2**ADDR_W");
    end
    if (READ_LAT < 1 || READ_LAT > MAX_READ_LAT) begin : g_bad_lat
        $error("data_memory_pipe: READ_LAT out of range 1..4");
    end

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              xfer;
    logic              in_range;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NBYTES-1:0] wr_be;
    logic [DATA_W-1:0] rd_data;

    assign xfer     = req_valid & req_ready;
    assign in_range = 32'(req_addr) < DEPTH;

    // Zero-fill shares the single write port with CPU stores.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = req_addr;
        wr_data = req_wdata;
        wr_be   = req_be;
        if (state == INIT) begin
            wr_en   = 1'b1;
            wr_addr = cnt;
            wr_data = '0;
            wr_be   = '1;
        end else if (xfer && req_write && in_range) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (in_range) begin
            rd_data = mem[req_addr];
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state     <= (INIT_ZERO != 0) ? INIT : RUN;
            cnt       <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == LAST) begin
                        state     <= RUN;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    req_ready <= 1'b1;
                    init_done <= 1'b1;
                end
            endcase
        end
    end

    dmem_rdpipe #(
        .DATA_W (DATA_W),
        .LAT    (READ_LAT)
    ) u_rdpipe (
        .clk       (sysclk),
        .rst       (rst),
        .in_valid  (xfer & ~req_write),
        .in_data   (rd_data),
        .in_err    (~in_range),
        .out_valid (rsp_valid),
        .out_data  (rsp_rdata),
        .out_err   (rsp_err)
    );

endmodule

// File: tb/tb_data_memory_pipe.sv
// Directed bench for data_memory_pipe across three parameter sets.
module tb_data_memory_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // a: 8-bit, DEPTH 256, READ_LAT 1
    logic       a_rst, a_valid, a_ready, a_write, a_rv, a_err, a_done;
    logic [7:0] a_addr, a_wdata, a_rdata;
    logic [0:0] a_be;
    // b: 32-bit, DEPTH 200, READ_LAT 3
    logic        b_rst, b_valid, b_ready, b_write, b_rv, b_err, b_done;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic [3:0]  b_be;
    // c: 8-bit, DEPTH 16, READ_LAT 2
    logic       c_rst, c_valid, c_ready, c_write, c_rv, c_err, c_done;
    logic [3:0] c_addr;
    logic [7:0] c_wdata, c_rdata;
    logic [0:0] c_be;

    data_memory_pipe #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .READ_LAT(1), .INIT_ZERO(1)) dut_a (
        .sysclk(clk), .rst(a_rst), .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
        .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be), .rsp_valid(a_rv),
        .rsp_rdata(a_rdata), .rsp_err(a_err), .init_done(a_done));

    data_memory_pipe #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .READ_LAT(3), .INIT_ZERO(1)) dut_b (
        .sysclk(clk), .rst(b_rst), .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
        .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be), .rsp_valid(b_rv),
        .rsp_rdata(b_rdata), .rsp_err(b_err), .init_done(b_done));

    data_memory_pipe #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .READ_LAT(2), .INIT_ZERO(1)) dut_c (
        .sysclk(clk), .rst(c_rst), .req_valid(c_valid), .req_ready(c_ready), .req_write(c_write),
        .req_addr(c_addr), .req_wdata(c_wdata), .req_be(c_be), .rsp_valid(c_rv),
        .rsp_rdata(c_rdata), .rsp_err(c_err), .init_done(c_done));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_req(input logic w, input logic [7:0] addr, input logic [7:0] data, input logic be);
        a_valid = 1'b1; a_write = w; a_addr = addr; a_wdata = data; a_be = be;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic b_req(input logic w, input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        b_valid = 1'b1; b_write = w; b_addr = addr; b_wdata = data; b_be = be;
        tick();
        b_valid = 1'b0;
    endtask

    task automatic c_req(input logic w, input logic [3:0] addr, input logic [7:0] data, input logic be);
        c_valid = 1'b1; c_write = w; c_addr = addr; c_wdata = data; c_be = be;
        tick();
        c_valid = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        tick();
        tick();
        checks++;
        if (a_ready !== 1'b0 || a_rv !== 1'b0 || a_rdata !== 8'h00 || a_err !== 1'b0 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: ready=%b rv=%b rdata=%h err=%b done=%b, required all zero",
                     a_ready, a_rv, a_rdata, a_err, a_done);
        end
        a_rst = 1'b0;
        n = 0;
        while (a_ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL init_len_a: ready after %0d cycles, required 256", n);
        end
        checks++;
        if (a_done !== 1'b1) begin
            errors++;
            $display("FAIL init_done_a: got %b, required 1", a_done);
        end
    endtask

    task automatic test_store_load();
        a_req(1'b1, 8'd7, 8'h5A, 1'b1);
        a_req(1'b0, 8'd7, 8'h00, 1'b0);
        checks++;
        if (a_rv !== 1'b1 || a_rdata !== 8'h5A || a_err !== 1'b0) begin
            errors++;
            $display("FAIL store_load_a: rv=%b rdata=%h err=%b, required 1/5a/0", a_rv, a_rdata, a_err);
        end
        tick();
        checks++;
        if (a_rv !== 1'b0 || a_rdata !== 8'h5A) begin
            errors++;
            $display("FAIL hold_a: rv=%b rdata=%h, required 0/5a", a_rv, a_rdata);
        end
    endtask

    task automatic test_zero_fill();
        a_req(1'b0, 8'hFF, 8'h00, 1'b0);
        checks++;
        if (a_rv !== 1'b1 || a_rdata !== 8'h00 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL zero_fill_a: rv=%b rdata=%h err=%b, required 1/00/0", a_rv, a_rdata, a_err);
        end
    endtask

    task automatic test_be_zero();
        a_req(1'b1, 8'd7, 8'h33, 1'b0);
        a_req(1'b0, 8'd7, 8'h00, 1'b0);
        checks++;
        if (a_rv !== 1'b1 || a_rdata !== 8'h5A) begin
            errors++;
            $display("FAIL be_zero_a: rv=%b rdata=%h, required 1/5a", a_rv, a_rdata);
        end
    endtask

    task automatic test_reset_b();
        int n;
        b_rst = 1'b0;
        n = 0;
        while (b_ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 200 || b_done !== 1'b1) begin
            errors++;
            $display("FAIL init_len_b: ready after %0d cycles done=%b, required 200/1", n, b_done);
        end
    endtask

    task automatic test_byte_enable();
        b_req(1'b1, 8'd5, 32'hDEADBEEF, 4'b1111);
        b_req(1'b1, 8'd5, 32'h00000011, 4'b0001);
        b_req(1'b0, 8'd5, 32'h0, 4'b0000);
        checks++;
        if (b_rv !== 1'b0) begin
            errors++;
            $display("FAIL lat_early1_b: rv=%b, required 0", b_rv);
        end
        tick();
        checks++;
        if (b_rv !== 1'b0) begin
            errors++;
            $display("FAIL lat_early2_b: rv=%b, required 0", b_rv);
        end
        tick();
        checks++;
        if (b_rv !== 1'b1 || b_rdata !== 32'hDEADBE11 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL byte_enable_b: rv=%b rdata=%h err=%b, required 1/deadbe11/0", b_rv, b_rdata, b_err);
        end
    endtask

    task automatic test_back_to_back();
        b_req(1'b1, 8'd1, 32'h00000111, 4'hF);
        b_req(1'b1, 8'd2, 32'h00000222, 4'hF);
        b_req(1'b1, 8'd3, 32'h00000333, 4'hF);
        b_req(1'b0, 8'd1, 32'h0, 4'h0);
        b_req(1'b0, 8'd2, 32'h0, 4'h0);
        b_req(1'b0, 8'd3, 32'h0, 4'h0);
        checks++;
        if (b_rv !== 1'b1 || b_rdata !== 32'h00000111) begin
            errors++;
            $display("FAIL b2b_rsp1: rv=%b rdata=%h, required 1/00000111", b_rv, b_rdata);
        end
        tick();
        checks++;
        if (b_rv !== 1'b1 || b_rdata !== 32'h00000222) begin
            errors++;
            $display("FAIL b2b_rsp2: rv=%b rdata=%h, required 1/00000222", b_rv, b_rdata);
        end
        tick();
        checks++;
        if (b_rv !== 1'b1 || b_rdata !== 32'h00000333) begin
            errors++;
            $display("FAIL b2b_rsp3: rv=%b rdata=%h, required 1/00000333", b_rv, b_rdata);
        end
        tick();
        checks++;
        if (b_rv !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: rv=%b, required 0", b_rv);
        end
    endtask

    task automatic test_out_of_range();
        b_req(1'b1, 8'd20, 32'h12345678, 4'hF);
        b_req(1'b1, 8'd220, 32'hFFFFFFFF, 4'hF);
        b_req(1'b0, 8'd220, 32'h0, 4'h0);
        b_req(1'b0, 8'd20, 32'h0, 4'h0);
        tick();
        checks++;
        if (b_rv !== 1'b1 || b_rdata !== 32'h0 || b_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_load_b: rv=%b rdata=%h err=%b, required 1/00000000/1", b_rv, b_rdata, b_err);
        end
        tick();
        checks++;
        if (b_rv !== 1'b1 || b_rdata !== 32'h12345678 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_alias_b: rv=%b rdata=%h err=%b, required 1/12345678/0", b_rv, b_rdata, b_err);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit saw_rv;
        c_rst = 1'b0;
        n = 0;
        while (c_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL init_len_c: ready after %0d cycles, required 16", n);
        end
        c_req(1'b1, 4'd3, 8'h77, 1'b1);
        c_req(1'b0, 4'd3, 8'h00, 1'b0);
        c_rst = 1'b1;
        tick();
        checks++;
        if (c_rv !== 1'b0 || c_done !== 1'b0 || c_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_c: rv=%b done=%b ready=%b, required 0/0/0", c_rv, c_done, c_ready);
        end
        c_rst = 1'b0;
        n = 0;
        saw_rv = 1'b0;
        while (c_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (c_rv === 1'b1) saw_rv = 1'b1;
        end
        checks++;
        if (n !== 16 || saw_rv !== 1'b0) begin
            errors++;
            $display("FAIL refill_c: ready after %0d cycles saw_rv=%b, required 16/0", n, saw_rv);
        end
        c_req(1'b0, 4'd3, 8'h00, 1'b0);
        tick();
        checks++;
        if (c_rv !== 1'b1 || c_rdata !== 8'h00) begin
            errors++;
            $display("FAIL refill_data_c: rv=%b rdata=%h, required 1/00", c_rv, c_rdata);
        end
    endtask

    initial begin
        a_rst = 1'b1; a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
        b_rst = 1'b1; b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
        c_rst = 1'b1; c_valid = 1'b0; c_write = 1'b0; c_addr = '0; c_wdata = '0; c_be = '0;
        test_reset();
        test_store_load();
        test_zero_fill();
        test_be_zero();
        test_reset_b();
        test_byte_enable();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
